// File: rtl/rib_uart_dump_pkg.sv
// Shared types and helpers for the RIB-to-UART memory dump engine.
package rib_uart_dump_pkg;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_HDR  = 3'd1,
      ST_RD   = 3'd2,
      ST_TX   = 3'd3,
      ST_CSUM = 3'd4,
      ST_DONE = 3'd5
   } state_e;

   function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         2'd3:    b = w[31:24];
         default: b = w[7:0];
      endcase
      return b;
   endfunction

   function automatic logic [7:0] csum_add(input logic [7:0] csum, input logic [7:0] b);
      return csum ^ b;
   endfunction

endpackage

// File: rtl/rib_uart_dump_uart_tx_byte.sv
// 8N1 byte serialiser; ready rises on the last stop-bit cycle so bytes can run back-to-back.
module uart_tx_byte #(
   parameter int BAUD_DIV = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       valid_i,
   input  logic [7:0] byte_i,
   output logic       ready_o,
   output logic       tx_o
);

   localparam int BW = $clog2(BAUD_DIV);

   logic          busy_q, busy_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [3:0]    left_q, left_d;
   logic [8:0]    shift_q, shift_d;
   logic          tx_q, tx_d;
   logic          last_s;

   assign last_s  = busy_q && (left_q == 4'd0) && (baud_q == {BW{1'b0}});
   assign ready_o = !busy_q || last_s;
   assign tx_o    = tx_q;

   // next-state: load a frame, advance one bit per baud period, or hold idle
   always_comb begin
      busy_d  = busy_q;
      baud_d  = baud_q;
      left_d  = left_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      if (valid_i && ready_o) begin
         busy_d  = 1'b1;
         tx_d    = 1'b0;
         shift_d = {1'b1, byte_i};
         left_d  = 4'd9;
         baud_d  = BW'(BAUD_DIV - 1);
      end else if (busy_q) begin
         if (baud_q == {BW{1'b0}}) begin
            if (left_q == 4'd0) begin
               busy_d = 1'b0;
            end else begin
               tx_d    = shift_q[0];
               shift_d = {1'b1, shift_q[8:1]};
               left_d  = left_q - 4'd1;
               baud_d  = BW'(BAUD_DIV - 1);
            end
         end else begin
            baud_d = baud_q - {{(BW-1){1'b0}}, 1'b1};
         end
      end else begin
         tx_d = 1'b1;
      end
   end

   // serialiser state register
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q  <= 1'b0;
         baud_q  <= {BW{1'b0}};
         left_q  <= 4'd0;
         shift_q <= 9'h1FF;
         tx_q    <= 1'b1;
      end else begin
         busy_q  <= busy_d;
         baud_q  <= baud_d;
         left_q  <= left_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
      end
   end

endmodule

// File: rtl/rib_uart_dump.sv
// Reads N words over a RIB master port and streams them out a UART as
// sync byte, data bytes (LSB-first), XOR checksum.
module rib_uart_dump
   import rib_uart_dump_pkg::*;
#(
   parameter int         BAUD_DIV  = 434,
   parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
   parameter int         CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [31:0]      base_addr_i,
   input  logic [CNT_W-1:0] word_cnt_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             req_o,
   output logic             mem_we_o,
   output logic [31:0]      mem_addr_o,
   output logic [31:0]      mem_wdata_o,
   input  logic [31:0]      mem_rdata_i,
   input  logic             mem_ready_i,
   output logic             tx_pin
);

   state_e           state_q, state_d;
   logic [31:0]      addr_q, addr_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic [31:0]      data_q, data_d;
   logic [7:0]       csum_q, csum_d;
   logic [2:0]       idx_q, idx_d;
   logic             req_q, req_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             tx_valid_s;
   logic [7:0]       tx_byte_s;
   logic             tx_ready_s;

   uart_tx_byte #(.BAUD_DIV(BAUD_DIV)) u_tx (
      .clk     (clk),
      .rst     (rst),
      .valid_i (tx_valid_s),
      .byte_i  (tx_byte_s),
      .ready_o (tx_ready_s),
      .tx_o    (tx_pin)
   );

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign req_o       = req_q;
   assign mem_addr_o  = addr_q;
   assign mem_we_o    = 1'b0;
   assign mem_wdata_o = 32'h0000_0000;

   // sequencing FSM: header, read/serialise each word, checksum, done pulse
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      rem_d      = rem_q;
      data_d     = data_q;
      csum_d     = csum_q;
      idx_d      = idx_q;
      tx_valid_s = 1'b0;
      tx_byte_s  = 8'h00;
      case (state_q)
         ST_IDLE: begin
            if (start_i && (word_cnt_i != {CNT_W{1'b0}})) begin
               state_d    = ST_HDR;
               addr_d     = base_addr_i & 32'hFFFF_FFFC;
               rem_d      = word_cnt_i;
               csum_d     = 8'h00;
               tx_valid_s = 1'b1;
               tx_byte_s  = SYNC_BYTE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_HDR: begin
            if (tx_ready_s) begin
               state_d = ST_RD;
            end else begin
               state_d = ST_HDR;
            end
         end
         // byte 0 leaves on the capture edge so each read costs one idle cycle
         ST_RD: begin
            if (mem_ready_i) begin
               data_d     = mem_rdata_i;
               tx_valid_s = 1'b1;
               tx_byte_s  = mem_rdata_i[7:0];
               csum_d     = csum_add(csum_q, mem_rdata_i[7:0]);
               addr_d     = addr_q + 32'd4;
               rem_d      = rem_q - CNT_W'(1);
               idx_d      = 3'd1;
               state_d    = ST_TX;
            end else begin
               state_d = ST_RD;
            end
         end
         ST_TX: begin
            if (idx_q != 3'd4) begin
               tx_valid_s = 1'b1;
               tx_byte_s  = word_byte(data_q, idx_q[1:0]);
               if (tx_ready_s) begin
                  csum_d = csum_add(csum_q, tx_byte_s);
                  idx_d  = idx_q + 3'd1;
               end else begin
                  idx_d = idx_q;
               end
            end else if (tx_ready_s) begin
               if (rem_q == {CNT_W{1'b0}}) begin
                  tx_valid_s = 1'b1;
                  tx_byte_s  = csum_q;
                  state_d    = ST_CSUM;
               end else begin
                  state_d = ST_RD;
               end
            end else begin
               state_d = ST_TX;
            end
         end
         ST_CSUM: begin
            if (tx_ready_s) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_CSUM;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      req_d  = (state_d == ST_RD);
      busy_d = (state_d == ST_HDR) || (state_d == ST_RD) ||
               (state_d == ST_TX)  || (state_d == ST_CSUM);
      done_d = (state_d == ST_DONE);
   end

   // state and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         addr_q  <= 32'h0000_0000;
         rem_q   <= {CNT_W{1'b0}};
         data_q  <= 32'h0000_0000;
         csum_q  <= 8'h00;
         idx_q   <= 3'd0;
         req_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         data_q  <= data_d;
         csum_q  <= csum_d;
         idx_q   <= idx_d;
         req_q   <= req_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_rib_uart_dump.sv
// Scoreboard bench: stimulus queues expected bytes/addresses, monitors decode the UART and RIB.
module tb_rib_uart_dump;

   localparam int BD = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_i = 1'b0;
   logic [31:0] base_addr_i = 32'h0;
   logic [15:0] word_cnt_i = 16'h0;
   logic        busy_o, done_o, req_o, mem_we_o, tx_pin;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic [31:0] mem_rdata_i = 32'h0;
   logic        mem_ready_i = 1'b0;

   int checks = 0;
   int errors = 0;

   logic [7:0]  exp_bytes[$];
   logic [31:0] rsp_data[$];
   logic [31:0] exp_addr[$];
   int          rsp_delay = 0;

   rib_uart_dump #(.BAUD_DIV(BD), .SYNC_BYTE(8'hA5), .CNT_W(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .start_i     (start_i),
      .base_addr_i (base_addr_i),
      .word_cnt_i  (word_cnt_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .req_o       (req_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_rdata_i (mem_rdata_i),
      .mem_ready_i (mem_ready_i),
      .tx_pin      (tx_pin)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // UART decoder: samples the second cycle of every bit and scores each byte
   initial begin : uart_mon
      int         off;
      logic [7:0] sh;
      bit         active;
      active = 1'b0;
      off = 0;
      sh = 8'h00;
      forever begin
         @(negedge clk);
         if (rst) begin
            active = 1'b0;
         end else if (!active) begin
            if (tx_pin == 1'b0) begin
               active = 1'b1;
               off = 0;
            end
         end else begin
            off++;
            if ((off % 4 == 1) && (off >= 5) && (off <= 33)) sh = {tx_pin, sh[7:1]};
            if (off == 37) begin
               check("stop_bit", {31'h0, tx_pin}, 32'h1);
               if (exp_bytes.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL tx_byte: got %h expected none", sh);
               end else begin
                  check("tx_byte", {24'h0, sh}, {24'h0, exp_bytes.pop_front()});
               end
               active = 1'b0;
            end
         end
      end
   end

   // RIB slave model: answers after rsp_delay wait cycles, checks address hold and idle line
   initial begin : mem_rsp
      int          wait_n;
      bit          started;
      bit          acked;
      logic [31:0] a_exp;
      wait_n = 0;
      started = 1'b0;
      acked = 1'b0;
      a_exp = 32'h0;
      forever begin
         @(negedge clk);
         if (rst) begin
            mem_ready_i = 1'b0;
            wait_n = 0;
            started = 1'b0;
            acked = 1'b0;
         end else if (acked) begin
            mem_ready_i = 1'b0;
            acked = 1'b0;
            check("req_drop", {31'h0, req_o}, 32'h0);
         end else if (req_o) begin
            if (!started) begin
               started = 1'b1;
               if (exp_addr.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL rd_addr: got %h expected none", mem_addr_o);
               end else begin
                  a_exp = exp_addr.pop_front();
               end
            end
            check("rd_addr", mem_addr_o, a_exp);
            check("rd_idle_line", {30'h0, tx_pin, mem_we_o}, 32'h2);
            if (wait_n < rsp_delay) begin
               wait_n++;
            end else begin
               mem_ready_i = 1'b1;
               mem_rdata_i = (rsp_data.size() != 0) ? rsp_data.pop_front() : 32'hDEAD_0000;
               wait_n = 0;
               started = 1'b0;
               acked = 1'b1;
            end
         end
      end
   end

   task automatic do_start(input logic [31:0] base, input logic [15:0] cnt);
      @(negedge clk);
      base_addr_i = base;
      word_cnt_i = cnt;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      check("start_busy_tx", {30'h0, busy_o, tx_pin}, 32'h2);
   endtask

   task automatic wait_done(input string name, output int cyc);
      cyc = 1;
      while (done_o !== 1'b1 && cyc < 3000) begin
         @(negedge clk);
         cyc++;
      end
      check(name, {31'h0, done_o}, 32'h1);
      @(negedge clk);
      check("done_single_pulse", {30'h0, done_o, busy_o}, 32'h0);
      check("bytes_left", exp_bytes.size(), 32'h0);
   endtask

   task automatic push_bytes(input logic [7:0] b[]);
      foreach (b[i]) exp_bytes.push_back(b[i]);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : stim
      int cyc;
      // 1: reset values, held and after release
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (i == 5) rst = 1'b0;
         check("reset_state", {25'h0, tx_pin, req_o, busy_o, done_o, mem_we_o,
                               |mem_addr_o, |mem_wdata_o}, 32'h40);
      end

      // 2: two words, zero-wait memory
      push_bytes('{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h88});
      rsp_data.push_back(32'h4433_2211);
      rsp_data.push_back(32'h8877_6655);
      exp_addr.push_back(32'h1000_0000);
      exp_addr.push_back(32'h1000_0004);
      rsp_delay = 0;
      do_start(32'h1000_0000, 16'd2);
      wait_done("done_frame2", cyc);
      // 10 bytes * 10 bits * 4 clk + 2 read cycles, done the cycle after the last stop bit
      checks++;
      if (cyc < 402 || cyc > 403) begin
         errors++;
         $display("FAIL frame2_len: got %0d cycles expected 402..403", cyc);
      end

      // 4a: zero count is ignored
      @(negedge clk);
      base_addr_i = 32'h5000_0000;
      word_cnt_i = 16'd0;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      for (int i = 0; i < 20; i++) begin
         check("cnt0_ignored", {28'h0, busy_o, req_o, done_o, tx_pin}, 32'h1);
         @(negedge clk);
      end

      // 3 + 4b: delayed ready, and a second start while busy
      push_bytes('{8'hA5, 8'h0D, 8'hF0, 8'hFE, 8'hCA, 8'hC9});
      rsp_data.push_back(32'hCAFE_F00D);
      exp_addr.push_back(32'h2000_0010);
      rsp_delay = 5;
      do_start(32'h2000_0013, 16'd1);
      repeat (60) @(negedge clk);
      start_i = 1'b1;
      base_addr_i = 32'h3000_0000;
      word_cnt_i = 16'd3;
      @(negedge clk);
      start_i = 1'b0;
      wait_done("done_frame3", cyc);

      // 5: address wraps past 2^32
      push_bytes('{8'hA5, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h04, 8'h03, 8'h02, 8'h01, 8'h26});
      rsp_data.push_back(32'hDEAD_BEEF);
      rsp_data.push_back(32'h0102_0304);
      exp_addr.push_back(32'hFFFF_FFFC);
      exp_addr.push_back(32'h0000_0000);
      rsp_delay = 1;
      do_start(32'hFFFF_FFFE, 16'd2);
      wait_done("done_frame5", cyc);

      // 6: reset mid third byte, then a clean frame
      push_bytes('{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h88});
      rsp_data.push_back(32'h4433_2211);
      rsp_data.push_back(32'h8877_6655);
      exp_addr.push_back(32'h4000_0000);
      exp_addr.push_back(32'h4000_0004);
      rsp_delay = 0;
      do_start(32'h4000_0000, 16'd2);
      repeat (98) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      exp_bytes.delete();
      rsp_data.delete();
      exp_addr.delete();
      check("abort_state", {28'h0, tx_pin, req_o, busy_o, done_o}, 32'h8);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("post_abort_idle", {28'h0, tx_pin, req_o, busy_o, done_o}, 32'h8);
      push_bytes('{8'hA5, 8'h3C, 8'h2D, 8'h1E, 8'h0F, 8'h00});
      rsp_data.push_back(32'h0F1E_2D3C);
      exp_addr.push_back(32'h6000_0004);
      do_start(32'h6000_0004, 16'd1);
      wait_done("done_frame6", cyc);

      repeat (5) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
